// File: rtl/acc_multicycle_core.sv
// acc_multicycle_core: parametrised multicycle accumulator core with a shared req/ready memory port
module acc_multicycle_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int REGS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] r0_out
);
  localparam int RIDX_W = $clog2(REGS);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir, r_a, r_b;
  logic [DATA_W-1:0] r_regs [REGS];
  logic [3:0]        w_op, w_f;
  logic [ADDR_W-1:0] w_opnd;
  logic [RIDX_W-1:0] w_i;
  logic [DATA_W-1:0] w_imm, w_res;
  logic              w_wr, w_access;
  assign w_op   = r_ir[DATA_W-1 -: 4];
  assign w_f    = r_ir[3:0];
  assign w_opnd = r_ir[ADDR_W-1:0];
  assign w_i    = r_ir[ADDR_W-1 -: RIDX_W];
  assign w_imm  = {{(DATA_W-ADDR_W){w_opnd[ADDR_W-1]}}, w_opnd};
  // ALU result for R0 from the operands latched in DECODE; w_wr marks ops that update R0
  always_comb begin
    w_res = r_a;
    w_wr  = 1'b1;
    case (w_op)
      4'd8: case (w_f)
        4'd1:    w_res = r_b;
        4'd2:    w_res = r_a + r_b;
        4'd3:    w_res = r_a - r_b;
        4'd4:    w_res = r_a & r_b;
        4'd5:    w_res = r_a | r_b;
        4'd6:    w_res = ~r_b;
        default: w_wr = 1'b0;
      endcase
      4'd12:   w_res = r_a + w_imm;
      4'd13:   w_res = r_a - w_imm;
      4'd14:   w_res = r_a & w_imm;
      4'd15:   w_res = r_a | w_imm;
      default: w_wr = 1'b0;
    endcase
  end
  // reset gates the request combinationally so an aborted access drops in the same cycle
  assign w_access  = r_state == S_FETCH || r_state == S_MEM;
  assign mem_req   = w_access && !rst;
  assign mem_we    = mem_req && r_state == S_MEM && w_op == 4'd1;
  assign mem_addr  = r_state == S_MEM ? w_opnd : r_pc;
  assign mem_wdata = r_regs[0];
  assign halted    = r_state == S_HALT;
  assign pc_out    = r_pc;
  assign r0_out    = r_regs[0];
  // control FSM and datapath state: fetch, operand latch, execute, optional memory access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      for (int k = 0; k < REGS; k++) r_regs[k] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + 1'b1;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= r_regs[0];
          r_b     <= r_regs[w_i];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_wr) r_regs[0] <= w_res;
          if (w_op == 4'd8 && w_f == 4'd0) r_regs[w_i] <= r_a;
          if (w_op == 4'd2 || (w_op == 4'd4 && r_a == '0)) r_pc <= w_opnd;
          r_state <= (w_op == 4'd0 || w_op == 4'd1) ? S_MEM : w_op == 4'd3 ? S_HALT : S_FETCH;
        end
        S_MEM: if (mem_ready) begin
          if (w_op == 4'd0) r_regs[0] <= mem_rdata;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule
